dut: RTL and testbench

DUT -- requirements
Module: dut

---
 rtl/dut_pkg.sv | 19 +
 rtl/dut_cmp.sv | 38 +++
 rtl/dut.sv | 50 +++++
 tb/tb_dut.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/dut_pkg.sv
// Shared defaults and command bit positions for the one-hot compare unit.
package dut_pkg;

    localparam int unsigned DEF_NUM_SIZE      = 32;
    localparam int unsigned DEF_CMD_SIZE_LOG2 = 3;
    localparam int unsigned NUM_CMDS          = 8;

    typedef enum int unsigned {
        CMD_EQ = 0,
        CMD_NE = 1,
        CMD_LT = 2,
        CMD_LE = 3,
        CMD_GT = 4,
        CMD_GE = 5,
        CMD_AND = 6,
        CMD_OR = 7
    } cmd_bit_e;

endpackage

// File: rtl/dut_cmp.sv
// Combinational predicate bank: all eight signed/logical predicates plus a
// flag marking cmd as exactly one-hot.
module dut_cmp
    import dut_pkg::*;
#(
    parameter int unsigned NUM_SIZE      = DEF_NUM_SIZE,
    parameter int unsigned CMD_SIZE_LOG2 = DEF_CMD_SIZE_LOG2
) (
    input  logic signed [NUM_SIZE-1:0]             a,
    input  logic signed [NUM_SIZE-1:0]             b,
    input  logic        [(2**CMD_SIZE_LOG2)-1:0]   cmd,
    output logic        [(2**CMD_SIZE_LOG2)-1:0]   pred,
    output logic                                   legal
);

    logic a_nz;
    logic b_nz;

    assign a_nz = (a != '0);
    assign b_nz = (b != '0);

    // Bits above the eight defined commands stay 0, so selecting them yields 0.
    always_comb begin
        pred          = '0;
        pred[CMD_EQ]  = (a == b);
        pred[CMD_NE]  = (a != b);
        pred[CMD_LT]  = (a < b);
        pred[CMD_LE]  = (a <= b);
        pred[CMD_GT]  = (a > b);
        pred[CMD_GE]  = (a >= b);
        pred[CMD_AND] = a_nz && b_nz;
        pred[CMD_OR]  = a_nz || b_nz;
    end

    // Non-zero with a single bit set: clearing the lowest set bit leaves nothing.
    assign legal = (cmd != '0) && ((cmd & (cmd - 1'b1)) == '0);

endmodule

// File: rtl/dut.sv
// Registered one-hot compare: selects one predicate from dut_cmp and holds it
// in a single flop; idle or multi-bit commands load 0.
module dut
    import dut_pkg::*;
#(
    parameter int unsigned NUM_SIZE      = DEF_NUM_SIZE,
    parameter int unsigned CMD_SIZE_LOG2 = DEF_CMD_SIZE_LOG2
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic signed [NUM_SIZE-1:0]             in1,
    input  logic signed [NUM_SIZE-1:0]             in2,
    input  logic        [(2**CMD_SIZE_LOG2)-1:0]   cmd,
    output logic                                   out
);

    logic [(2**CMD_SIZE_LOG2)-1:0] pred;
    logic                          legal;
    logic                          out_d;
    logic                          out_q;

    dut_cmp #(
        .NUM_SIZE      (NUM_SIZE),
        .CMD_SIZE_LOG2 (CMD_SIZE_LOG2)
    ) u_cmp (
        .a     (in1),
        .b     (in2),
        .cmd   (cmd),
        .pred  (pred),
        .legal (legal)
    );

    always_comb begin
        out_d = 1'b0;
        if (legal) begin
            out_d = |(pred & cmd);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_q <= 1'b0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule

// File: tb/tb_dut.sv
// Directed vector table, hand sequences for reset/hold timing, and a random
// run against an independent reference model.
module tb_dut;

    logic        clk;
    logic        rst_n;
    logic [31:0] in1;
    logic [31:0] in2;
    logic [7:0]  cmd;
    logic        out;

    int checks = 0;
    int errors = 0;

    dut u_dut (
        .clk   (clk),
        .reset (rst_n),
        .in1   (in1),
        .in2   (in2),
        .cmd   (cmd),
        .out   (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  c;
        logic        exp;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic model(input logic [31:0] a, input logic [31:0] b,
                                   input logic [7:0] c);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        sa = a;
        sb = b;
        case (c)
            8'h01:   return sa == sb;
            8'h02:   return sa != sb;
            8'h04:   return sa < sb;
            8'h08:   return sa <= sb;
            8'h10:   return sa > sb;
            8'h20:   return sa >= sb;
            8'h40:   return (a != 0) && (b != 0);
            8'h80:   return (a != 0) || (b != 0);
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [7:0] c);
        @(negedge clk);
        in1 = a;
        in2 = b;
        cmd = c;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [7:0]  rc;

        vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 8'h04, 1'b1};
        vecs[1]  = '{32'hFFFF_FFFF, 32'h0000_0001, 8'h10, 1'b0};
        vecs[2]  = '{32'hFFFF_FFFF, 32'h0000_0001, 8'h02, 1'b1};
        vecs[3]  = '{32'h8000_0000, 32'h7FFF_FFFF, 8'h08, 1'b1};
        vecs[4]  = '{32'h8000_0000, 32'h7FFF_FFFF, 8'h20, 1'b0};
        vecs[5]  = '{32'h8000_0000, 32'h8000_0000, 8'h01, 1'b1};
        vecs[6]  = '{32'h0000_0000, 32'h0000_0007, 8'h40, 1'b0};
        vecs[7]  = '{32'h0000_0000, 32'h0000_0007, 8'h80, 1'b1};
        vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 8'h80, 1'b0};
        vecs[9]  = '{32'h0000_0003, 32'h0000_0003, 8'h00, 1'b0};
        vecs[10] = '{32'h0000_0003, 32'h0000_0003, 8'h03, 1'b0};
        vecs[11] = '{32'h7FFF_FFFF, 32'h8000_0000, 8'h10, 1'b1};
        vecs[12] = '{32'h0000_0005, 32'h0000_0005, 8'h20, 1'b1};
        vecs[13] = '{32'h0000_0005, 32'h0000_0005, 8'h04, 1'b0};
        vecs[14] = '{32'hFFFF_FFFD, 32'h0000_0002, 8'h40, 1'b1};
        vecs[15] = '{32'h0000_0003, 32'h0000_0003, 8'h01, 1'b1};

        // Reset held low with a true EQ on the inputs.
        rst_n = 1'b0;
        in1   = 32'd5;
        in2   = 32'd5;
        cmd   = 8'h01;
        #1;
        check("reset_async", out, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("reset_hold", out, 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", out, 1'b1);

        // Back-to-back directed vectors, one result per cycle.
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].c);
            check($sformatf("vec%0d", i), out, vecs[i].exp);
        end

        // Inputs changing between edges must not reach out until the next edge.
        @(negedge clk);
        in1 = 32'd0;
        in2 = 32'd9;
        #2;
        check("hold_between_edges", out, 1'b1);
        @(posedge clk);
        #1;
        check("after_edge_update", out, 1'b0);

        // Random run with one asynchronous reset pulse in the middle.
        for (int i = 0; i < 1000; i++) begin
            if (i == 500) begin
                @(negedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                check("midrun_reset_async", out, 1'b0);
                @(posedge clk);
                #1;
                check("midrun_reset_hold", out, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
            end
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
            case ($urandom_range(0, 15))
                0:       ra = 32'd0;
                1:       rb = 32'd0;
                2:       ra = 32'h8000_0000;
                3:       rb = 32'h7FFF_FFFF;
                default: ;
            endcase
            rc = 8'h01 << $urandom_range(0, 7);
            drive(ra, rb, rc);
            check($sformatf("rand%0d", i), out, model(ra, rb, rc));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
